aq_djpeg_mcu_sched: RTL and testbench

//  Scan-level scheduler for the Huffman decode datapath. Walks MCUs and the blocks inside each MCU.
//  Per block: issues one start pulse tagged with its colour, then waits for the decoder's end-of-block pulse.

---
 rtl/aq_djpeg_pkg.sv | 49 ++++
 rtl/aq_djpeg_mcu_seq.sv | 25 ++
 rtl/aq_djpeg_mcu_sched.sv | 175 +++++++++++++++++
 tb/tb_aq_djpeg_mcu_sched.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aq_djpeg_pkg.sv
// Shared definitions for the JPEG scan scheduler: MCU mode and colour codes,
// FSM state encoding and the blocks-per-MCU helper.
package aq_djpeg_pkg;

  localparam int unsigned ModeW  = 2;
  localparam int unsigned ColorW = 3;
  localparam int unsigned BlkW   = 3;

  typedef enum logic [ModeW-1:0] {
    ModeGray = 2'd0,
    Mode444  = 2'd1,
    Mode422  = 2'd2,
    Mode420  = 2'd3
  } mcuMode_e;

  typedef enum logic [ColorW-1:0] {
    ColorY0 = 3'd0,
    ColorY1 = 3'd1,
    ColorY2 = 3'd2,
    ColorY3 = 3'd3,
    ColorCb = 3'd4,
    ColorCr = 3'd5
  } color_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StIssue   = 3'd1,
    StWait    = 3'd2,
    StRstWait = 3'd3,
    StDone    = 3'd4
  } state_e;

  typedef struct packed {
    color_e color;
    logic   lastBlock;
  } seqInfo_t;

  function automatic logic [BlkW-1:0] blocksPerMcu(input mcuMode_e mode);
    logic [BlkW-1:0] n;
    unique case (mode)
      ModeGray: n = 3'd1;
      Mode444:  n = 3'd3;
      Mode422:  n = 3'd4;
      Mode420:  n = 3'd6;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/aq_djpeg_mcu_seq.sv
// Block sequencer: maps (MCU mode, block index) to the block colour and a
// last-block-of-MCU flag.
module aq_djpeg_mcu_seq
  import aq_djpeg_pkg::*;
(
  input  mcuMode_e        mcuMode,
  input  logic [BlkW-1:0] blk,
  output seqInfo_t        info
);

  always_comb begin
    info.color     = ColorY0;
    info.lastBlock = (blk == BlkW'(blocksPerMcu(mcuMode) - 3'd1));
    unique case (mcuMode)
      ModeGray: info.color = ColorY0;
      Mode444:  info.color = (blk == 3'd0) ? ColorY0 :
                             (blk == 3'd1) ? ColorCb : ColorCr;
      Mode422:  info.color = (blk < 3'd2)  ? color_e'(blk) :
                             (blk == 3'd2) ? ColorCb : ColorCr;
      Mode420:  info.color = (blk < 3'd4)  ? color_e'(blk) :
                             (blk == 3'd4) ? ColorCb : ColorCr;
    endcase
  end

endmodule

// File: rtl/aq_djpeg_mcu_sched.sv
// Scan-level scheduler for the Huffman decode path: walks MCUs and their blocks,
// enforces the restart interval and flags decoder handshake violations.
module aq_djpeg_mcu_sched
  import aq_djpeg_pkg::*;
#(
  parameter int unsigned MCU_W = 24,
  parameter int unsigned RI_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ProcessInit,
  input  logic [1:0]        McuMode,
  input  logic [MCU_W-1:0]  McuTotal,
  input  logic [RI_W-1:0]   RestartInterval,
  input  logic              OutBufFull,
  input  logic              BlockDone,
  input  logic              RestartAck,
  output logic              BlockStart,
  output logic [2:0]        BlockColor,
  output logic              DcReset,
  output logic              RestartReq,
  output logic              ScanBusy,
  output logic              ScanDone,
  output logic [MCU_W-1:0]  McuCount,
  output logic              ProtocolError
);

  state_e            state, stateNxt;
  mcuMode_e          modeQ, modeNxt;
  logic [MCU_W-1:0]  totalQ, totalNxt;
  logic [RI_W-1:0]   riQ, riNxt;
  logic [RI_W-1:0]   rstCnt, rstCntNxt;
  logic [BlkW-1:0]   blk, blkNxt;
  logic [MCU_W-1:0]  mcuCountNxt;
  logic              blockStartNxt;
  logic [2:0]        blockColorNxt;
  logic              dcResetNxt;
  logic              restartReqNxt;
  logic              scanBusyNxt;
  logic              scanDoneNxt;
  logic              protoErrNxt;
  logic              blockAccept;
  seqInfo_t          seqInfo;

  aq_djpeg_mcu_seq uSeq (
    .mcuMode (modeQ),
    .blk     (blk),
    .info    (seqInfo)
  );

  // A BlockDone coinciding with its own BlockStart is rejected as a violation.
  assign blockAccept = BlockDone && (state == StWait) && !BlockStart;

  // Next-state, counter and output computation.
  always_comb begin
    stateNxt      = state;
    modeNxt       = modeQ;
    totalNxt      = totalQ;
    riNxt         = riQ;
    rstCntNxt     = rstCnt;
    blkNxt        = blk;
    mcuCountNxt   = McuCount;
    blockStartNxt = 1'b0;
    blockColorNxt = BlockColor;
    dcResetNxt    = 1'b0;
    restartReqNxt = RestartReq;
    scanBusyNxt   = ScanBusy;
    scanDoneNxt   = 1'b0;
    protoErrNxt   = ProtocolError;

    if (ProcessInit) begin
      modeNxt       = mcuMode_e'(McuMode);
      totalNxt      = McuTotal;
      riNxt         = RestartInterval;
      rstCntNxt     = '0;
      blkNxt        = '0;
      mcuCountNxt   = '0;
      dcResetNxt    = 1'b1;
      restartReqNxt = 1'b0;
      scanBusyNxt   = 1'b1;
      protoErrNxt   = 1'b0;
      stateNxt      = (McuTotal == '0) ? StDone : StIssue;
    end else begin
      if (BlockDone && !blockAccept) begin
        protoErrNxt = 1'b1;
      end
      if (RestartAck && (state != StRstWait)) begin
        protoErrNxt = 1'b1;
      end

      unique case (state)
        StIdle: begin
        end
        StIssue: begin
          if (!OutBufFull) begin
            blockStartNxt = 1'b1;
            blockColorNxt = seqInfo.color;
            stateNxt      = StWait;
          end
        end
        StWait: begin
          if (blockAccept) begin
            if (!seqInfo.lastBlock) begin
              blkNxt   = blk + 3'd1;
              stateNxt = StIssue;
            end else begin
              blkNxt      = '0;
              mcuCountNxt = McuCount + MCU_W'(1);
              rstCntNxt   = (riQ == '0) ? '0 : rstCnt + RI_W'(1);
              // Scan end takes priority so no restart is requested after the last MCU.
              if ((McuCount + MCU_W'(1)) == totalQ) begin
                stateNxt = StDone;
              end else if ((riQ != '0) && ((rstCnt + RI_W'(1)) == riQ)) begin
                restartReqNxt = 1'b1;
                stateNxt      = StRstWait;
              end else begin
                stateNxt = StIssue;
              end
            end
          end
        end
        StRstWait: begin
          if (RestartAck) begin
            restartReqNxt = 1'b0;
            dcResetNxt    = 1'b1;
            rstCntNxt     = '0;
            stateNxt      = StIssue;
          end
        end
        StDone: begin
          scanDoneNxt = 1'b1;
          scanBusyNxt = 1'b0;
          stateNxt    = StIdle;
        end
        default: stateNxt = StIdle;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      modeQ         <= ModeGray;
      totalQ        <= '0;
      riQ           <= '0;
      rstCnt        <= '0;
      blk           <= '0;
      McuCount      <= '0;
      BlockStart    <= 1'b0;
      BlockColor    <= '0;
      DcReset       <= 1'b0;
      RestartReq    <= 1'b0;
      ScanBusy      <= 1'b0;
      ScanDone      <= 1'b0;
      ProtocolError <= 1'b0;
    end else begin
      state         <= stateNxt;
      modeQ         <= modeNxt;
      totalQ        <= totalNxt;
      riQ           <= riNxt;
      rstCnt        <= rstCntNxt;
      blk           <= blkNxt;
      McuCount      <= mcuCountNxt;
      BlockStart    <= blockStartNxt;
      BlockColor    <= blockColorNxt;
      DcReset       <= dcResetNxt;
      RestartReq    <= restartReqNxt;
      ScanBusy      <= scanBusyNxt;
      ScanDone      <= scanDoneNxt;
      ProtocolError <= protoErrNxt;
    end
  end

endmodule

// File: tb/tb_aq_djpeg_mcu_sched.sv
// Self-checking bench for aq_djpeg_mcu_sched: transaction-level scan model,
// reactive decoder/bit-reader responder and directed scenarios.
module tb_aq_djpeg_mcu_sched;

  localparam int unsigned MCU_W = 24;
  localparam int unsigned RI_W  = 16;

  logic              clk;
  logic              rst;
  logic              ProcessInit;
  logic [1:0]        McuMode;
  logic [MCU_W-1:0]  McuTotal;
  logic [RI_W-1:0]   RestartInterval;
  logic              OutBufFull;
  logic              BlockDone;
  logic              RestartAck;
  logic              BlockStart;
  logic [2:0]        BlockColor;
  logic              DcReset;
  logic              RestartReq;
  logic              ScanBusy;
  logic              ScanDone;
  logic [MCU_W-1:0]  McuCount;
  logic              ProtocolError;

  aq_djpeg_mcu_sched #(.MCU_W(MCU_W), .RI_W(RI_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .ProcessInit     (ProcessInit),
    .McuMode         (McuMode),
    .McuTotal        (McuTotal),
    .RestartInterval (RestartInterval),
    .OutBufFull      (OutBufFull),
    .BlockDone       (BlockDone),
    .RestartAck      (RestartAck),
    .BlockStart      (BlockStart),
    .BlockColor      (BlockColor),
    .DcReset         (DcReset),
    .RestartReq      (RestartReq),
    .ScanBusy        (ScanBusy),
    .ScanDone        (ScanDone),
    .McuCount        (McuCount),
    .ProtocolError   (ProtocolError)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int bpmOf(input int m);
    case (m)
      0: return 1;
      1: return 3;
      2: return 4;
      default: return 6;
    endcase
  endfunction

  // Colour of block idx within an MCU: Y0..Y3 = 0..3, Cb = 4, Cr = 5.
  function automatic int colorOf(input int m, input int idx);
    case (m)
      0: return 0;
      1: return (idx == 0) ? 0 : (idx == 1) ? 4 : 5;
      2: return (idx < 2) ? idx : idx + 2;
      default: return idx;
    endcase
  endfunction

  // ---------------- scan model ----------------
  int mMode = 0, mTotal = 0, mRi = 0;
  int doneCnt = 0, lastAcked = -1, scanGen = 0;
  bit scanActive = 0, sdPending = 0;
  bit expDc = 0, expBusy = 0, expScanDone = 0, expPerr = 0, fullAtEdge = 0;

  function automatic bit expRr();
    int mcus;
    mcus = doneCnt / bpmOf(mMode);
    return scanActive && (mRi != 0) && (mcus > 0) && ((mcus % mRi) == 0) &&
           (mcus < mTotal) && (lastAcked != mcus);
  endfunction

  initial begin
    bit rrNow;
    forever begin
      @(posedge clk);
      fullAtEdge  = OutBufFull;
      rrNow       = expRr();
      expScanDone = sdPending;
      sdPending   = 0;
      if (rst) begin
        mMode = 0; mTotal = 0; mRi = 0; doneCnt = 0; lastAcked = -1;
        scanActive = 0; expDc = 0; expBusy = 0; expScanDone = 0; expPerr = 0;
        scanGen++;
      end else if (ProcessInit) begin
        mMode = int'(McuMode); mTotal = int'(McuTotal); mRi = int'(RestartInterval);
        doneCnt = 0; lastAcked = -1; scanGen++;
        expDc = 1; expBusy = 1; expPerr = 0; expScanDone = 0;
        scanActive = (mTotal != 0);
        sdPending  = (mTotal == 0);
      end else begin
        expDc = 0;
        if (expScanDone) expBusy = 0;
        if (BlockDone) begin
          if (scanActive) begin
            doneCnt++;
            if (doneCnt == mTotal * bpmOf(mMode)) begin
              scanActive = 0;
              sdPending  = 1;
            end
          end else begin
            expPerr = 1;
          end
        end
        if (RestartAck) begin
          if (rrNow) begin
            lastAcked = doneCnt / bpmOf(mMode);
            expDc = 1;
          end else begin
            expPerr = 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmpEn = 0;
  int startCnt = 0, dcCnt = 0, rrCnt = 0, rrMcu = -1, scanDoneCnt = 0;
  int colLog [0:255];

  initial begin
    int startIdx = 0, lastGen = -1;
    bit prevStart = 0, prevRr = 0;
    forever begin
      @(negedge clk);
      if (cmpEn) begin
        if (scanGen != lastGen) begin
          startIdx = 0;
          lastGen  = scanGen;
        end
        check("dcReset",     int'(DcReset),       int'(expDc));
        check("scanBusy",    int'(ScanBusy),      int'(expBusy));
        check("scanDone",    int'(ScanDone),      int'(expScanDone));
        check("restartReq",  int'(RestartReq),    int'(expRr()));
        check("mcuCount",    int'(McuCount),      doneCnt / bpmOf(mMode));
        check("protoErr",    int'(ProtocolError), int'(expPerr));
        check("startInRst",  int'(BlockStart & RestartReq), 0);
        if (BlockStart) begin
          check("blockColor",     int'(BlockColor), colorOf(mMode, startIdx % bpmOf(mMode)));
          check("startWhileFull", int'(fullAtEdge), 0);
          check("startBackToBack", int'(prevStart), 0);
          if (startCnt < 256) colLog[startCnt] = int'(BlockColor);
          startIdx++;
          startCnt++;
        end
        if (DcReset) dcCnt++;
        if (ScanDone) scanDoneCnt++;
        if (RestartReq && !prevRr) begin
          rrCnt++;
          rrMcu = int'(McuCount);
        end
      end
      prevStart = BlockStart;
      prevRr    = RestartReq;
    end
  end

  // ---------------- decoder / bit-reader responder ----------------
  int doneLat = 3, ackLat = 2;
  bit ackEn = 1, strayDone = 0;

  initial begin
    int doneCtr = -1, ackCtr = -1;
    bit ackFired = 0;
    BlockDone  = 1'b0;
    RestartAck = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      BlockDone  = 1'b0;
      RestartAck = 1'b0;
      if (strayDone) begin
        BlockDone = 1'b1;
        strayDone = 0;
      end
      if (doneCtr > 0) begin
        doneCtr--;
        if (doneCtr == 0) begin
          BlockDone = 1'b1;
          doneCtr   = -1;
        end
      end
      if (BlockStart) doneCtr = doneLat;
      if (!RestartReq) ackFired = 0;
      if (ackCtr > 0) begin
        ackCtr--;
        if (ackCtr == 0) begin
          RestartAck = 1'b1;
          ackCtr     = -1;
          ackFired   = 1;
        end
      end else if (RestartReq && ackEn && !ackFired && ackCtr < 0) begin
        ackCtr = ackLat;
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic initScan(input int mode, input int total, input int ri);
    McuMode         = 2'(mode);
    McuTotal        = MCU_W'(total);
    RestartInterval = RI_W'(ri);
    ProcessInit     = 1'b1;
    tick();
    ProcessInit     = 1'b0;
    McuMode         = ~McuMode;
    McuTotal        = MCU_W'(total + 7);
    RestartInterval = RI_W'(ri + 1);
  endtask

  task automatic waitDone(input string name, input int budget);
    int sd0;
    sd0 = scanDoneCnt;
    for (int i = 0; i < budget && scanDoneCnt == sd0; i++) tick();
    check(name, (scanDoneCnt != sd0) ? 1 : 0, 1);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".BlockStart"},    int'(BlockStart),    0);
    check({tag, ".BlockColor"},    int'(BlockColor),    0);
    check({tag, ".DcReset"},       int'(DcReset),       0);
    check({tag, ".RestartReq"},    int'(RestartReq),    0);
    check({tag, ".ScanBusy"},      int'(ScanBusy),      0);
    check({tag, ".ScanDone"},      int'(ScanDone),      0);
    check({tag, ".McuCount"},      int'(McuCount),      0);
    check({tag, ".ProtocolError"}, int'(ProtocolError), 0);
  endtask

  initial begin
    int s0, d0, r0, p0, p1;
    rst = 1'b1; ProcessInit = 1'b0; McuMode = '0; McuTotal = '0;
    RestartInterval = '0; OutBufFull = 1'b0;
    tick(3);
    checkAllZero("reset");
    rst   = 1'b0;
    cmpEn = 1;
    tick(2);

    // 4:2:0, two MCUs, no restarts
    s0 = startCnt; d0 = dcCnt;
    initScan(3, 2, 0);
    waitDone("t1.done", 200);
    tick(3);
    check("t1.starts", startCnt - s0, 12);
    check("t1.mcuCount", int'(McuCount), 2);
    check("t1.dcResets", dcCnt - d0, 1);
    p0 = 0; p1 = 0;
    for (int i = 0; i < 6; i++) begin
      p0 = p0 * 8 + colLog[s0 + i];
      p1 = p1 * 8 + colLog[s0 + 6 + i];
    end
    check("t1.mcu0Colours", p0, 'o012345);
    check("t1.mcu1Colours", p1, 'o012345);

    // 4:4:4, four MCUs, restart every two, slow acknowledge
    ackLat = 10;
    s0 = startCnt; d0 = dcCnt; r0 = rrCnt;
    initScan(1, 4, 2);
    waitDone("t2.done", 400);
    tick(3);
    check("t2.restartReqs", rrCnt - r0, 1);
    check("t2.restartAtMcu", rrMcu, 2);
    check("t2.dcResets", dcCnt - d0, 2);
    check("t2.starts", startCnt - s0, 12);
    check("t2.mcuCount", int'(McuCount), 4);
    ackLat = 2;

    // gray, downstream full for 20 cycles
    s0 = startCnt;
    OutBufFull = 1'b1;
    initScan(0, 2, 0);
    tick(19);
    check("t3.noStartWhileFull", startCnt - s0, 0);
    OutBufFull = 1'b0;
    tick(2);
    check("t3.oneStartAfterRelease", startCnt - s0, 1);
    waitDone("t3.done", 100);
    check("t3.starts", startCnt - s0, 2);

    // abort while waiting for RST marker
    ackEn = 0;
    initScan(1, 4, 1);
    for (int i = 0; i < 200 && !RestartReq; i++) tick();
    check("t4.reachedRstWait", int'(RestartReq), 1);
    tick(3);
    check("t4.mcuBeforeAbort", int'(McuCount), 1);
    ackEn = 1;
    s0 = startCnt;
    initScan(0, 3, 0);
    check("t4.restartReqDropped", int'(RestartReq), 0);
    check("t4.dcReset", int'(DcReset), 1);
    check("t4.mcuCleared", int'(McuCount), 0);
    waitDone("t4.done", 200);
    check("t4.mcuCount", int'(McuCount), 3);
    check("t4.starts", startCnt - s0, 3);
    check("t4.noError", int'(ProtocolError), 0);

    // empty scan
    s0 = startCnt;
    initScan(2, 0, 0);
    check("t5.dcReset", int'(DcReset), 1);
    check("t5.busy", int'(ScanBusy), 1);
    tick();
    check("t5.scanDone", int'(ScanDone), 1);
    check("t5.busyDropped", int'(ScanBusy), 0);
    tick(5);
    check("t5.noStart", startCnt - s0, 0);

    // stray BlockDone in IDLE
    strayDone = 1;
    tick(3);
    check("t6.errorSet", int'(ProtocolError), 1);
    tick(5);
    check("t6.errorSticky", int'(ProtocolError), 1);
    initScan(0, 1, 0);
    check("t6.errorCleared", int'(ProtocolError), 0);
    waitDone("t6.done", 100);

    // reset in the middle of a scan
    initScan(3, 5, 0);
    tick(40);
    check("t7.midScanProgress", (int'(McuCount) > 0) ? 1 : 0, 1);
    rst = 1'b1;
    tick();
    checkAllZero("t7.reset");
    rst = 1'b0;
    tick(8);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
